pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and sequencing controller for the pd5 five-stage RISC-V core. It sits beside the F/D/X/M/W pipeline registers inside the core and drives their stall and bubble enables. It also drives the X-stage operand forwarding selects. It sequences boot after reset, load-use stalls, branch/jump redirect flushes and data-memory wait states, and keeps stall and flush performance counters.

## Interface
Parameters:
- BOOT_CYCLES, 2: cycles of fetch hold and flush after reset release; minimum 1.
- MEM_TIMEOUT, 16: consecutive unready memory-wait cycles before `mem_err` sets.
- CNT_W, 32: width of the performance counters.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- clock  in  1  core clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- rs1_d, rs2_d  in  5  source registers of the instruction in D.
- use_rs1_d, use_rs2_d  in  1  the D instruction actually reads that source.
- rs1_x, rs2_x  in  5  source registers of the instruction in X.
- rd_x  in  5;  we_x  in  1;  load_x  in  1  destination, write enable and load flag of the instruction in X.
- rd_m  in  5;  we_m  in  1  destination and write enable of the instruction in M.
- rd_w  in  5;  we_w  in  1  destination and write enable of the instruction in W.
- br_taken_x  in  1  redirect (taken branch, jal, jalr) resolved in X.
- mem_req_m  in  1  load or store active in M.
- mem_ready_m  in  1  data memory completes the M access this cycle.
- stall_f, stall_d, stall_x, stall_m  out  1  hold the PC, D, X and M registers.
- flush_d  out  1  replace D with a nop.
- bubble_x  out  1  insert a nop into X.
- bubble_w  out  1  insert a nop into W.
- fwd_a_x, fwd_b_x  out  2  operand select: 00 = register file, 01 = M-stage ALU result, 10 = W write-back data.
- stall_cnt, flush_cnt  out  CNT_W  count of cycles with stall_d=1, and count of accepted redirects.
- mem_err  out  1  sticky memory-timeout flag.

## Operation
- The FSM has three states: BOOT, RUN and MEM_WAIT. Reset forces BOOT, clears both counters and clears `mem_err`.
- BOOT drives stall_f=1, flush_d=1 and bubble_x=1. It lasts BOOT_CYCLES cycles after reset release, then moves to RUN.
- In RUN, priority is memory wait, then redirect, then load-use.
  - Memory wait: `mem_req_m && !mem_ready_m`. Drive stall_f, stall_d, stall_x and stall_m to 1, and bubble_w=1. Enter MEM_WAIT.
  - Redirect: `br_taken_x`. Drive flush_d=1 and bubble_x=1; all stalls are 0. Increment flush_cnt. Any load-use condition in the same cycle is discarded (the D instruction is wrong-path).
  - Load-use: `load_x && we_x && rd_x!=0` and the D instruction uses a matching source (`use_rs1_d && rs1_d==rd_x`, or `use_rs2_d && rs2_d==rd_x`). Drive stall_f=1, stall_d=1, bubble_x=1 for exactly one cycle. No state change.
- In MEM_WAIT, the memory-wait outputs are held and br_taken_x is ignored (X is frozen, so the redirect is re-evaluated after release).
  - The wait-cycle counter starts at 1 on entry and increments each unready cycle.
  - When the counter reaches MEM_TIMEOUT, `mem_err` sets. It stays set until reset; the state stays MEM_WAIT.
  - When mem_ready_m=1: outputs are those of RUN for that cycle, then the state returns to RUN.
- Forwarding (X stage, purely combinational, per operand): M has priority over W. Register x0 never forwards.
  - 01 if `we_m && rd_m!=0 && rd_m==rs_x`.
  - else 10 if `we_w && rd_w!=0 && rd_w==rs_x`.
  - else 00.
- Counters wrap modulo 2^CNT_W.

## Timing
- All outputs are Mealy: combinational from the current state plus the current-cycle inputs. Same-cycle response with zero latency.
- State, counters and `mem_err` update on the rising edge of `clock`.
- Outputs while reset=1: stall_f=1, flush_d=1, bubble_x=1; all other outputs 0.
- Reset asserted mid-MEM_WAIT or mid-BOOT: the next state is BOOT and the counters clear. No memory handshake is owed.
- A load-use stall never lasts longer than 1 cycle, because the load advances to M on the next edge.
- A single unready cycle costs 1 stall cycle. The cycle in which ready rises is not a stall.

## Structure
- Package `pd_ctrl_pkg` holds:
  - the state enum (BOOT, RUN, MEM_WAIT);
  - the forwarding-select constants FWD_RF=2'b00, FWD_M=2'b01, FWD_W=2'b10;
  - the register-index width constant 5.
- Sub-module `hazard_fwd_unit`: the combinational forwarding compare, instantiated once and driving both operands. The FSM and counters stay in `pipeline_ctrl`.

## Test plan
- Reset: hold reset for 3 cycles, then release with BOOT_CYCLES=2 -> cycles 1-2 show stall_f=1, flush_d=1, bubble_x=1; cycle 3 has all controls 0; stall_cnt=0.
- Load-use: load_x=1, we_x=1, rd_x=5, rs1_d=5, use_rs1_d=1 -> one cycle with stall_f=stall_d=bubble_x=1 and stall_cnt becomes 1. Repeat with rd_x=0, or with use_rs1_d=0 -> no stall.
- Redirect and load-use in the same cycle: br_taken_x=1 plus the load-use case above -> flush_d=1, bubble_x=1, stall_f=0, flush_cnt +1, stall_cnt unchanged.
- Memory wait: mem_req_m=1, mem_ready_m=0 for 3 cycles, then 1 -> 3 cycles with all four stalls and bubble_w=1, 0 on the ready cycle, stall_cnt +3. Assert br_taken_x during the wait -> no flush.
- Timeout: MEM_TIMEOUT=4 and ready never arrives -> mem_err=1 from the 4th wait cycle and stays 1 after ready. Reset clears it.
- Forwarding: rs1_x=7, rd_m=7, we_m=1, rd_w=7, we_w=1 -> fwd_a_x=01. Set we_m=0 -> 10. Set rs1_x=0 -> 00.

Source files
------------

// File: rtl/pd_ctrl_pkg.sv
// Shared types and constants for the pd5 pipeline hazard/sequencing controller.
// Holds the controller state enum, forwarding-select encodings and the forwarding compare.
package pd_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    // M beats W because it holds the younger write; x0 is hardwired zero and never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rd_m,
        input logic             we_m,
        input logic [REG_W-1:0] rd_w,
        input logic             we_w
    );
        if (we_m && (rd_m != '0) && (rd_m == rs))
            return FWD_M;
        else if (we_w && (rd_w != '0) && (rd_w == rs))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// X-stage operand forwarding select for both source operands.
// Latency: purely combinational. Backpressure: none, follows its inputs every cycle.
module hazard_fwd_unit
    import pd_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs1_x,
    input  logic [REG_W-1:0] rs2_x,
    input  logic [REG_W-1:0] rd_m,
    input  logic             we_m,
    input  logic [REG_W-1:0] rd_w,
    input  logic             we_w,
    output logic [1:0]       fwd_a_x,
    output logic [1:0]       fwd_b_x
);

    always_comb begin
        fwd_a_x = fwd_sel(rs1_x, rd_m, we_m, rd_w, we_w);
        fwd_b_x = fwd_sel(rs2_x, rd_m, we_m, rd_w, we_w);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pd5 pipeline controller: boot hold, load-use stall, redirect flush, data-memory wait, perf counters.
// Latency: all outputs Mealy, zero-cycle; state/counters/mem_err update on the clock edge.
// Backpressure: an unready M access freezes F/D/X/M and bubbles W until mem_ready_m.
module pipeline_ctrl
    import pd_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic             use_rs1_d,
    input  logic             use_rs2_d,
    input  logic [REG_W-1:0] rs1_x,
    input  logic [REG_W-1:0] rs2_x,
    input  logic [REG_W-1:0] rd_x,
    input  logic             we_x,
    input  logic             load_x,
    input  logic [REG_W-1:0] rd_m,
    input  logic             we_m,
    input  logic [REG_W-1:0] rd_w,
    input  logic             we_w,
    input  logic             br_taken_x,
    input  logic             mem_req_m,
    input  logic             mem_ready_m,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_x,
    output logic             stall_m,
    output logic             flush_d,
    output logic             bubble_x,
    output logic             bubble_w,
    output logic [1:0]       fwd_a_x,
    output logic [1:0]       fwd_b_x,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);

    localparam int BC_W = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_t      state, state_nxt;
    logic [BC_W-1:0]  boot_cnt;
    logic [WC_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic             boot_done;
    logic             mem_wait;
    logic             load_use;
    logic             flush_inc;
    logic [1:0]       fwd_a_raw, fwd_b_raw;

    hazard_fwd_unit u_fwd (
        .rs1_x   (rs1_x),
        .rs2_x   (rs2_x),
        .rd_m    (rd_m),
        .we_m    (we_m),
        .rd_w    (rd_w),
        .we_w    (we_w),
        .fwd_a_x (fwd_a_raw),
        .fwd_b_x (fwd_b_raw)
    );

    assign boot_done = (boot_cnt == BC_W'(BOOT_CYCLES - 1));
    assign mem_wait  = mem_req_m && !mem_ready_m;
    assign load_use  = load_x && we_x && (rd_x != '0) &&
                       ((use_rs1_d && (rs1_d == rd_x)) || (use_rs2_d && (rs2_d == rd_x)));
    assign fwd_a_x   = reset ? FWD_RF : fwd_a_raw;
    assign fwd_b_x   = reset ? FWD_RF : fwd_b_raw;

    always_comb begin
        state_nxt = state;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_x   = 1'b0;
        stall_m   = 1'b0;
        flush_d   = 1'b0;
        bubble_x  = 1'b0;
        bubble_w  = 1'b0;
        flush_inc = 1'b0;
        if (reset) begin
            state_nxt = BOOT;
            stall_f   = 1'b1;
            flush_d   = 1'b1;
            bubble_x  = 1'b1;
        end else begin
            unique case (state)
                BOOT: begin
                    stall_f  = 1'b1;
                    flush_d  = 1'b1;
                    bubble_x = 1'b1;
                    if (boot_done)
                        state_nxt = RUN;
                end
                // MEM_WAIT shares RUN's decode: while unready the wait branch masks the redirect,
                // and the ready cycle behaves exactly like RUN.
                RUN, MEM_WAIT: begin
                    if (mem_wait) begin
                        state_nxt = MEM_WAIT;
                        stall_f   = 1'b1;
                        stall_d   = 1'b1;
                        stall_x   = 1'b1;
                        stall_m   = 1'b1;
                        bubble_w  = 1'b1;
                    end else begin
                        state_nxt = RUN;
                        if (br_taken_x) begin
                            flush_d   = 1'b1;
                            bubble_x  = 1'b1;
                            flush_inc = 1'b1;
                        end else if (load_use) begin
                            stall_f  = 1'b1;
                            stall_d  = 1'b1;
                            bubble_x = 1'b1;
                        end
                    end
                end
                default: state_nxt = BOOT;
            endcase
        end
    end

    always_comb begin
        wait_cnt_nxt = '0;
        if (state_nxt == MEM_WAIT) begin
            if (state != MEM_WAIT)
                wait_cnt_nxt = WC_W'(1);
            else if (wait_cnt != WC_W'(MEM_TIMEOUT))
                wait_cnt_nxt = wait_cnt + WC_W'(1);
            else
                wait_cnt_nxt = wait_cnt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= BOOT;
            boot_cnt  <= '0;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            mem_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if ((state == BOOT) && !boot_done)
                boot_cnt <= boot_cnt + BC_W'(1);
            if (stall_d)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc)
                flush_cnt <= flush_cnt + CNT_W'(1);
            if ((state_nxt == MEM_WAIT) && (wait_cnt_nxt == WC_W'(MEM_TIMEOUT)))
                mem_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (BOOT_CYCLES=2, MEM_TIMEOUT=4).
module tb_pipeline_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rs1_d, rs2_d, rs1_x, rs2_x, rd_x, rd_m, rd_w;
    logic        use_rs1_d, use_rs2_d, we_x, load_x, we_m, we_w;
    logic        br_taken_x, mem_req_m, mem_ready_m;
    logic        stall_f, stall_d, stall_x, stall_m, flush_d, bubble_x, bubble_w;
    logic [1:0]  fwd_a_x, fwd_b_x;
    logic [31:0] stall_cnt, flush_cnt;
    logic        mem_err;
    logic [6:0]  ctrl;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    // {stall_f, stall_d, stall_x, stall_m, flush_d, bubble_x, bubble_w}
    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_BOOT = 7'b1000110;
    localparam logic [6:0] C_LU   = 7'b1100010;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_MEM  = 7'b1111001;

    assign ctrl = {stall_f, stall_d, stall_x, stall_m, flush_d, bubble_x, bubble_w};

    always #5 clock = ~clock;

    pipeline_ctrl #(.BOOT_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clock(clock), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
        .rs1_x(rs1_x), .rs2_x(rs2_x), .rd_x(rd_x), .we_x(we_x), .load_x(load_x),
        .rd_m(rd_m), .we_m(we_m), .rd_w(rd_w), .we_w(we_w),
        .br_taken_x(br_taken_x), .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
        .stall_f(stall_f), .stall_d(stall_d), .stall_x(stall_x), .stall_m(stall_m),
        .flush_d(flush_d), .bubble_x(bubble_x), .bubble_w(bubble_w),
        .fwd_a_x(fwd_a_x), .fwd_b_x(fwd_b_x),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
    );

    task automatic idle_inputs();
        rs1_d = 0; rs2_d = 0; use_rs1_d = 0; use_rs2_d = 0;
        rs1_x = 0; rs2_x = 0; rd_x = 0; we_x = 0; load_x = 0;
        rd_m = 0; we_m = 0; rd_w = 0; we_w = 0;
        br_taken_x = 0; mem_req_m = 0; mem_ready_m = 0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_load_use_rs1();
        load_x = 1; we_x = 1; rd_x = 5; rs1_d = 5; use_rs1_d = 1;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        next_cycle();
        #1;
        n_checks++;
        if (ctrl !== C_BOOT) begin
            n_fail++; $display("FAIL reset_outputs ctrl=%b expected=%b", ctrl, C_BOOT);
        end
        next_cycle();
        next_cycle();
        reset = 0;
        for (int c = 1; c <= 2; c++) begin
            #1;
            n_checks++;
            if (ctrl !== C_BOOT) begin
                n_fail++; $display("FAIL boot_cycle%0d ctrl=%b expected=%b", c, ctrl, C_BOOT);
            end
            next_cycle();
        end
        #1;
        n_checks++;
        if (ctrl !== C_IDLE) begin
            n_fail++; $display("FAIL run_after_boot ctrl=%b expected=%b", ctrl, C_IDLE);
        end
        n_checks++;
        if (stall_cnt !== 0 || flush_cnt !== 0 || mem_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_counters stall_cnt=%0d flush_cnt=%0d mem_err=%b expected 0/0/0",
                               stall_cnt, flush_cnt, mem_err);
        end
    endtask

    task automatic test_forwarding();
        rs1_x = 7; rd_m = 7; we_m = 1; rd_w = 7; we_w = 1; rs2_x = 3;
        #1;
        n_checks++;
        if (fwd_a_x !== 2'b01 || fwd_b_x !== 2'b00) begin
            n_fail++; $display("FAIL fwd_m_priority a=%b b=%b expected a=01 b=00", fwd_a_x, fwd_b_x);
        end
        we_m = 0; rs2_x = 7;
        #1;
        n_checks++;
        if (fwd_a_x !== 2'b10 || fwd_b_x !== 2'b10) begin
            n_fail++; $display("FAIL fwd_w a=%b b=%b expected a=10 b=10", fwd_a_x, fwd_b_x);
        end
        rs1_x = 0; rd_m = 0; rd_w = 0; we_m = 1;
        #1;
        n_checks++;
        if (fwd_a_x !== 2'b00) begin
            n_fail++; $display("FAIL fwd_x0 a=%b expected=00", fwd_a_x);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_load_use();
        set_load_use_rs1();
        #1;
        n_checks++;
        if (ctrl !== C_LU) begin
            n_fail++; $display("FAIL load_use_rs1 ctrl=%b expected=%b", ctrl, C_LU);
        end
        exp_stall++;
        next_cycle();
        idle_inputs();
        #1;
        n_checks++;
        if (stall_cnt !== exp_stall || ctrl !== C_IDLE) begin
            n_fail++; $display("FAIL load_use_one_cycle stall_cnt=%0d ctrl=%b expected %0d/%b",
                               stall_cnt, ctrl, exp_stall, C_IDLE);
        end
        set_load_use_rs1(); rd_x = 0; rs1_d = 0;
        #1;
        n_checks++;
        if (ctrl !== C_IDLE) begin
            n_fail++; $display("FAIL load_use_rd_x0 ctrl=%b expected=%b", ctrl, C_IDLE);
        end
        next_cycle();
        set_load_use_rs1(); use_rs1_d = 0;
        #1;
        n_checks++;
        if (ctrl !== C_IDLE) begin
            n_fail++; $display("FAIL load_use_unused_src ctrl=%b expected=%b", ctrl, C_IDLE);
        end
        next_cycle();
        idle_inputs();
        load_x = 1; we_x = 1; rd_x = 9; rs2_d = 9; use_rs2_d = 1; rs1_d = 9;
        #1;
        n_checks++;
        if (ctrl !== C_LU) begin
            n_fail++; $display("FAIL load_use_rs2 ctrl=%b expected=%b", ctrl, C_LU);
        end
        exp_stall++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_redirect();
        set_load_use_rs1();
        br_taken_x = 1;
        #1;
        n_checks++;
        if (ctrl !== C_BR) begin
            n_fail++; $display("FAIL redirect_over_load_use ctrl=%b expected=%b", ctrl, C_BR);
        end
        exp_flush++;
        next_cycle();
        idle_inputs();
        #1;
        n_checks++;
        if (flush_cnt !== exp_flush || stall_cnt !== exp_stall) begin
            n_fail++; $display("FAIL redirect_counters flush_cnt=%0d stall_cnt=%0d expected %0d/%0d",
                               flush_cnt, stall_cnt, exp_flush, exp_stall);
        end
    endtask

    task automatic test_mem_wait();
        for (int c = 1; c <= 3; c++) begin
            mem_req_m = 1; mem_ready_m = 0;
            br_taken_x = (c == 2);
            #1;
            n_checks++;
            if (ctrl !== C_MEM) begin
                n_fail++; $display("FAIL mem_wait_cycle%0d ctrl=%b expected=%b", c, ctrl, C_MEM);
            end
            exp_stall++;
            next_cycle();
        end
        mem_ready_m = 1; br_taken_x = 1;
        #1;
        n_checks++;
        if (ctrl !== C_BR) begin
            n_fail++; $display("FAIL mem_ready_cycle ctrl=%b expected=%b", ctrl, C_BR);
        end
        exp_flush++;
        next_cycle();
        idle_inputs();
        #1;
        n_checks++;
        if (stall_cnt !== exp_stall || flush_cnt !== exp_flush || mem_err !== 1'b0) begin
            n_fail++; $display("FAIL mem_wait_counters stall_cnt=%0d flush_cnt=%0d mem_err=%b expected %0d/%0d/0",
                               stall_cnt, flush_cnt, mem_err, exp_stall, exp_flush);
        end
    endtask

    task automatic test_timeout();
        for (int c = 1; c <= 6; c++) begin
            mem_req_m = 1; mem_ready_m = 0;
            #1;
            n_checks++;
            if (ctrl !== C_MEM) begin
                n_fail++; $display("FAIL timeout_wait%0d ctrl=%b expected=%b", c, ctrl, C_MEM);
            end
            if (c == 3) begin
                n_checks++;
                if (mem_err !== 1'b0) begin
                    n_fail++; $display("FAIL timeout_early mem_err=%b expected=0", mem_err);
                end
            end
            if (c >= 5) begin
                n_checks++;
                if (mem_err !== 1'b1) begin
                    n_fail++; $display("FAIL timeout_set_wait%0d mem_err=%b expected=1", c, mem_err);
                end
            end
            exp_stall++;
            next_cycle();
        end
        mem_ready_m = 1;
        #1;
        n_checks++;
        if (ctrl !== C_IDLE || mem_err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_release ctrl=%b mem_err=%b expected %b/1", ctrl, mem_err, C_IDLE);
        end
        next_cycle();
        idle_inputs();
        #1;
        n_checks++;
        if (mem_err !== 1'b1 || stall_cnt !== exp_stall) begin
            n_fail++; $display("FAIL timeout_sticky mem_err=%b stall_cnt=%0d expected 1/%0d",
                               mem_err, stall_cnt, exp_stall);
        end
    endtask

    task automatic test_reset_mid_wait();
        mem_req_m = 1; mem_ready_m = 0;
        next_cycle();
        next_cycle();
        reset = 1;
        #1;
        n_checks++;
        if (ctrl !== C_BOOT) begin
            n_fail++; $display("FAIL reset_in_wait ctrl=%b expected=%b", ctrl, C_BOOT);
        end
        next_cycle();
        reset = 0;
        mem_req_m = 0;
        #1;
        n_checks++;
        if (mem_err !== 1'b0 || stall_cnt !== 0 || flush_cnt !== 0 || ctrl !== C_BOOT) begin
            n_fail++; $display("FAIL reset_clears mem_err=%b stall_cnt=%0d flush_cnt=%0d ctrl=%b expected 0/0/0/%b",
                               mem_err, stall_cnt, flush_cnt, ctrl, C_BOOT);
        end
        next_cycle();
        next_cycle();
        #1;
        n_checks++;
        if (ctrl !== C_IDLE) begin
            n_fail++; $display("FAIL rerun_after_reset ctrl=%b expected=%b", ctrl, C_IDLE);
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
